// File: rtl/capture_ctrl.sv
// Triggered ADC capture controller: writes valid samples into a circular buffer until a
// level-crossing trigger plus post_count samples, then exposes a readout pointer.
module capture_ctrl #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] post_count,
    input  logic [DATA_W-1:0] adc_d,
    input  logic              adc_valid,
    input  logic              rd_next,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              wrapped,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   post_left_q, post_left_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                wrapped_q, wrapped_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                trig_hit_c;
    logic [ADDR_W-1:0]   wr_inc_c;

    // Crossing detect needs a previous valid sample since arm
    always_comb begin
        trig_hit_c = 1'b0;
        if (prev_vld_q) begin
            if (trig_rising) trig_hit_c = (prev_q < trig_level) && (adc_d >= trig_level);
            else             trig_hit_c = (prev_q >= trig_level) && (adc_d < trig_level);
        end
    end

    assign wr_inc_c = wr_ptr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_left_d = post_left_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        wrapped_d   = wrapped_q;
        trig_addr_d = trig_addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d    = S_ARMED;
                        wr_ptr_d   = '0;
                        wrapped_d  = 1'b0;
                        prev_vld_d = 1'b0;
                    end else if (state_q == S_DONE) begin
                        // Read address trails the pointer by one cycle
                        mem_addr_d = rd_ptr_q;
                        if (rd_next) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    end
                end
                S_ARMED, S_POST: begin
                    if (adc_valid) begin
                        mem_we_d   = 1'b1;
                        mem_data_d = adc_d;
                        mem_addr_d = wr_ptr_q;
                        wr_ptr_d   = wr_inc_c;
                        prev_d     = adc_d;
                        prev_vld_d = 1'b1;
                        if (wr_ptr_q == '1) wrapped_d = 1'b1;
                        if (state_q == S_ARMED) begin
                            if (trig_hit_c) begin
                                trig_addr_d = wr_ptr_q;
                                post_left_d = post_count;
                                if (post_count != '0) begin
                                    state_d = S_POST;
                                end else begin
                                    state_d  = S_DONE;
                                    rd_ptr_d = wr_inc_c;
                                end
                            end
                        end else begin
                            post_left_d = post_left_q - ADDR_W'(1);
                            if (post_left_q == ADDR_W'(1)) begin
                                state_d  = S_DONE;
                                rd_ptr_d = wr_inc_c;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_POST);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_left_q <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_left_q <= post_left_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            wrapped_q   <= wrapped_d;
            trig_addr_q <= trig_addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign trig_addr = trig_addr_q;
    assign wrapped   = wrapped_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus randomized captures checked
// against a sample-stream model of the capture rules.
module tb_capture_ctrl;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int NENT = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm, abort, trig_rising, adc_valid, rd_next;
    logic [DATA_W-1:0] trig_level, adc_d;
    logic [ADDR_W-1:0] post_count;
    logic              mem_we, wrapped, busy, done;
    logic [ADDR_W-1:0] mem_addr, trig_addr;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        state;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0]        st_d[$];
    bit                       st_v[$];
    logic [DATA_W-1:0]        exp_wd[$];
    logic [ADDR_W+DATA_W-1:0] dut_wr[$];
    int                       exp_trig;
    bit                       exp_done;

    capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_level(trig_level), .trig_rising(trig_rising), .post_count(post_count),
        .adc_d(adc_d), .adc_valid(adc_valid), .rd_next(rd_next),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .trig_addr(trig_addr), .wrapped(wrapped), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && mem_we) dut_wr.push_back({mem_addr, mem_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Walk the valid samples in order: every one is stored until the trigger plus post_count
    task automatic model(input logic [DATA_W-1:0] lvl, input bit rise, input int pc);
        logic [DATA_W-1:0] p;
        bit have_p;
        int left;
        exp_wd.delete();
        exp_trig = -1;
        exp_done = 0;
        have_p   = 0;
        p        = '0;
        left     = 0;
        for (int i = 0; i < st_d.size(); i++) begin
            if (exp_done) break;
            if (st_v[i]) begin
                exp_wd.push_back(st_d[i]);
                if (exp_trig < 0) begin
                    if (have_p && (rise ? (int'(p) < int'(lvl) && int'(st_d[i]) >= int'(lvl))
                                        : (int'(p) >= int'(lvl) && int'(st_d[i]) < int'(lvl)))) begin
                        exp_trig = exp_wd.size() - 1;
                        left = pc;
                        if (pc == 0) exp_done = 1;
                    end
                end else begin
                    left--;
                    if (left == 0) exp_done = 1;
                end
                p = st_d[i];
                have_p = 1;
            end
        end
    endtask

    task automatic run_capture(input string name, input logic [DATA_W-1:0] lvl, input bit rise, input int pc);
        int total, rd;
        model(lvl, rise, pc);
        @(negedge clk);
        trig_level  = lvl;
        trig_rising = rise;
        post_count  = ADDR_W'(pc);
        dut_wr.delete();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk({name, "_armed"}, 32'(state), 32'd1);
        for (int i = 0; i < st_d.size(); i++) begin
            adc_d     = st_d[i];
            adc_valid = st_v[i];
            @(negedge clk);
            #1;
            if (done) break;
        end
        adc_valid = 1'b0;
        if (exp_done) begin
            total = exp_wd.size();
            rd    = total % NENT;
            chk({name, "_done"}, 32'(done), 32'd1);
            chk({name, "_state"}, 32'(state), 32'd3);
            chk({name, "_busy"}, 32'(busy), 32'd0);
            chk({name, "_trig_addr"}, 32'(trig_addr), 32'(exp_trig % NENT));
            chk({name, "_wrapped"}, 32'(wrapped), 32'(total >= NENT));
            chk({name, "_nwrites"}, 32'(dut_wr.size()), 32'(total));
            for (int k = 0; k < total && k < dut_wr.size(); k++) begin
                chk({name, "_waddr"}, 32'(dut_wr[k][ADDR_W+DATA_W-1:DATA_W]), 32'(k % NENT));
                chk({name, "_wdata"}, 32'(dut_wr[k][DATA_W-1:0]), 32'(exp_wd[k]));
            end
            @(negedge clk);
            #1;
            chk({name, "_rd_addr"}, 32'(mem_addr), 32'(rd));
            chk({name, "_rd_we"}, 32'(mem_we), 32'd0);
            rd_next = 1'b1;
            @(negedge clk);
            rd_next = 1'b0;
            @(negedge clk);
            #1;
            chk({name, "_rd_next"}, 32'(mem_addr), 32'((rd + 1) % NENT));
            chk({name, "_nowrite_done"}, 32'(dut_wr.size()), 32'(total));
        end else begin
            chk({name, "_still_armed"}, 32'(state), 32'd1);
            chk({name, "_busy_armed"}, 32'(busy), 32'd1);
            chk({name, "_nwrites_armed"}, 32'(dut_wr.size()), 32'(exp_wd.size()));
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk({name, "_abort_idle"}, 32'(state), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_state"}, 32'(state), 32'd0);
        chk({name, "_we"}, 32'(mem_we), 32'd0);
        chk({name, "_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_data"}, 32'(mem_data), 32'd0);
        chk({name, "_trig_addr"}, 32'(trig_addr), 32'd0);
        chk({name, "_wrapped"}, 32'(wrapped), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_rising = 1'b1; adc_valid = 1'b0;
        rd_next = 1'b0; trig_level = '0; adc_d = '0; post_count = '0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Rising trigger on the third sample with five post samples
        st_d = '{8'h10, 8'h20, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97};
        st_v = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_capture("rise", 8'h80, 1'b1, 5);

        // Falling trigger; the first sample must not trigger
        st_d = '{8'h10, 8'h50, 8'h30, 8'h31, 8'h32};
        st_v = '{1, 1, 1, 1, 1};
        run_capture("fall", 8'h40, 1'b0, 1);

        // Buffer wrap then trigger with post_count=0
        st_d.delete(); st_v.delete();
        for (int i = 0; i < 8200; i++) begin st_d.push_back(8'h10); st_v.push_back(1); end
        st_d.push_back(8'h90); st_v.push_back(1);
        run_capture("wrap", 8'h80, 1'b1, 0);

        // Arm and abort together leave IDLE untouched
        @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_state", 32'(state), 32'd0);

        // Valid gaps in ARMED: writes only on valid edges
        trig_level = 8'hff; trig_rising = 1'b1; post_count = ADDR_W'(3);
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        adc_d = 8'h11; adc_valid = 1'b1; @(negedge clk);
        chk("gap_we0", 32'(mem_we), 32'd1);
        chk("gap_addr0", 32'(mem_addr), 32'd0);
        adc_valid = 1'b0; @(negedge clk);
        chk("gap_we1", 32'(mem_we), 32'd0);
        adc_d = 8'h22; adc_valid = 1'b1; @(negedge clk);
        chk("gap_we2", 32'(mem_we), 32'd1);
        chk("gap_addr2", 32'(mem_addr), 32'd1);
        chk("gap_data2", 32'(mem_data), 32'h22);
        adc_d = 8'h33; @(negedge clk);
        chk("gap_addr3", 32'(mem_addr), 32'd2);
        adc_valid = 1'b0;

        // Abort during POST
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        trig_level = 8'h80; post_count = ADDR_W'(20);
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        adc_valid = 1'b1;
        adc_d = 8'h10; @(negedge clk);
        adc_d = 8'h90; @(negedge clk);
        adc_d = 8'h10; @(negedge clk);
        chk("post_state", 32'(state), 32'd2);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("abort_post_state", 32'(state), 32'd0);
        chk("abort_post_we", 32'(mem_we), 32'd0);
        chk("abort_post_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("abort_post_nowrite", 32'(mem_we), 32'd0);
        adc_valid = 1'b0;

        // Asynchronous reset mid-POST
        arm = 1'b1; @(negedge clk); arm = 1'b0;
        adc_valid = 1'b1;
        adc_d = 8'h10; @(negedge clk);
        adc_d = 8'h90; @(negedge clk);
        adc_d = 8'h95; @(negedge clk);
        chk("pre_rst_post", 32'(state), 32'd2);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk("rst_hold_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        adc_valid = 1'b0;

        // Randomized captures
        for (int r = 0; r < 8; r++) begin
            logic [DATA_W-1:0] lvl;
            st_d.delete(); st_v.delete();
            for (int i = 0; i < 90; i++) begin
                st_d.push_back(DATA_W'($urandom_range(0, 255)));
                st_v.push_back($urandom_range(0, 3) != 0);
            end
            lvl = DATA_W'($urandom_range(16, 240));
            run_capture($sformatf("rand%0d", r), lvl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 25)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
